// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared opcodes, control encodings and FSM states for the multicycle controller
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_IMMEX, S_IMMWB
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADDI = 3'b011;
  localparam logic [2:0] ALU_SLTI = 3'b100;
  localparam logic [2:0] ALU_SUBNE = 3'b101;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;
  // S_FETCH as the result marks an undecodable opcode
  function automatic state_t dec_target(input logic [5:0] op, input bit en_bne, input bit en_slti);
    return op == OP_R ? S_EXEC :
      (op == OP_LW || op == OP_SW) ? S_MEMADR :
      (op == OP_BEQ || (en_bne && op == OP_BNE)) ? S_BRANCH :
      op == OP_J ? S_JUMP :
      (op == OP_ADDI || (en_slti && op == OP_SLTI)) ? S_IMMEX : S_FETCH;
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/mem_ready inputs and datapath control outputs of the controller
interface multicycle_control_if;
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  modport master (
    output opcode, mem_ready,
    input pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
    input mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, alu_src_b, pc_source, alu_op, state
  );
  modport slave (
    input opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, alu_src_b, pc_source, alu_op, state
  );
endinterface

// File: rtl/mc_out_decode.sv
// mc_out_decode: Moore decode of FSM state (plus opcode) into datapath controls
module mc_out_decode import multicycle_control_pkg::*; #(
  parameter bit EN_BNE = 1'b1,
  parameter bit EN_SLTI = 1'b1
) (
  input state_t st,
  input logic mr,
  input logic rst,
  multicycle_control_if.slave bus
);
  always_comb begin
    bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne = 1'b0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst = 1'b0;
    bus.reg_write = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.illegal = 1'b0;
    bus.alu_src_b = SRCB_REG;
    bus.pc_source = PCS_ALU;
    bus.alu_op = ALU_ADD;
    // reset forces FETCH, so gating FETCH strobes keeps every strobe low under rst
    case (st)
      S_FETCH: begin
        bus.mem_read = !rst;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write = mr && !rst;
        bus.pc_write = mr && !rst;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM2;
        bus.illegal = dec_target(bus.opcode, EN_BNE, EN_SLTI) == S_FETCH;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.pc_write_cond = 1'b1;
        bus.pc_source = PCS_ALUOUT;
        bus.branch_ne = bus.opcode == OP_BNE;
        bus.alu_op = bus.opcode == OP_BNE ? ALU_SUBNE : ALU_SUB;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_source = PCS_JUMP;
      end
      S_IMMEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op = bus.opcode == OP_SLTI ? ALU_SLTI : ALU_ADDI;
      end
      S_IMMWB: bus.reg_write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM; state register and next-state logic
module multicycle_control import multicycle_control_pkg::*; #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EN_BNE = 1'b1,
  parameter bit EN_SLTI = 1'b1
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.slave bus
);
  state_t st, nx;
  logic mr;
  assign mr = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign bus.state = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= S_FETCH;
    else st <= nx;
  always_comb begin
    nx = S_FETCH;
    case (st)
      S_FETCH: nx = mr ? S_DECODE : S_FETCH;
      S_DECODE: nx = dec_target(bus.opcode, EN_BNE, EN_SLTI);
      S_MEMADR: nx = bus.opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD: nx = mr ? S_MEMWB : S_MEMRD;
      S_MEMWR: nx = mr ? S_FETCH : S_MEMWR;
      S_EXEC: nx = S_ALUWB;
      S_IMMEX: nx = S_IMMWB;
      default: nx = S_FETCH;
    endcase
  end
  mc_out_decode #(.EN_BNE(EN_BNE), .EN_SLTI(EN_SLTI)) u_dec (
    .st(st), .mr(mr), .rst(rst), .bus(bus)
  );
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level model check of the controller plus directed literal checks
module tb_multicycle_control;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, SLTI = 6'b001010;
  localparam logic [5:0] BAD = 6'b111111;
  typedef struct packed {
    logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic illegal;
  } outs_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  multicycle_control_if bus0();
  multicycle_control_if bus1();
  multicycle_control u0 (.clk(clk), .rst(rst), .bus(bus0));
  multicycle_control #(.MEM_WAIT(1'b0), .EN_BNE(1'b0), .EN_SLTI(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  int n_cmp = 0, n_bad = 0;
  logic exp_valid = 1'b0;
  logic [3:0] exp_state;
  outs_t exp_o;
  logic [3:0] trace[$];
  outs_t otrace[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic outs_t outs0();
    return '{bus0.pc_write, bus0.pc_write_cond, bus0.branch_ne, bus0.iord, bus0.mem_read,
             bus0.mem_write, bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write,
             bus0.alu_src_a, bus0.alu_src_b, bus0.pc_source, bus0.alu_op, bus0.illegal};
  endfunction

  function automatic logic [6:0] strobes0();
    return {bus0.pc_write, bus0.pc_write_cond, bus0.ir_write, bus0.mem_read,
            bus0.mem_write, bus0.reg_write, bus0.illegal};
  endfunction

  // what each state must drive, straight from the control table of the datapath
  function automatic outs_t exp_outs(input int s, input logic [5:0] op, input logic mr);
    outs_t o = '0;
    if (s == 0) begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
    if (s == 1) begin
      o.alu_src_b = 2'b11;
      o.illegal = !(op inside {R, LW, SW, BEQ, BNE, J, ADDI, SLTI});
    end
    if (s == 2) begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
    if (s == 3) begin o.mem_read = 1; o.iord = 1; end
    if (s == 4) begin o.reg_write = 1; o.mem_to_reg = 1; end
    if (s == 5) begin o.mem_write = 1; o.iord = 1; end
    if (s == 6) begin o.alu_src_a = 1; o.alu_op = 3'b010; end
    if (s == 7) begin o.reg_write = 1; o.reg_dst = 1; end
    if (s == 8) begin
      o.alu_src_a = 1; o.pc_write_cond = 1; o.pc_source = 2'b01;
      o.branch_ne = op == BNE; o.alu_op = op == BNE ? 3'b101 : 3'b001;
    end
    if (s == 9) begin o.pc_write = 1; o.pc_source = 2'b10; end
    if (s == 10) begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = op == SLTI ? 3'b100 : 3'b011; end
    if (s == 11) o.reg_write = 1;
    return o;
  endfunction

  always @(negedge clk)
    if (exp_valid) begin : cmp
      outs_t a;
      a = outs0();
      trace.push_back(bus0.state);
      otrace.push_back(a);
      chk("state", {28'd0, bus0.state}, {28'd0, exp_state});
      chk("outputs", {13'd0, a}, {13'd0, exp_o});
    end

  // one instruction from FETCH: fw stalled fetch cycles, mw stalled memory cycles
  task automatic run(input logic [5:0] op, input int fw, input int mw);
    int st[$];
    logic mq[$];
    for (int i = 0; i < fw; i++) begin st.push_back(0); mq.push_back(1'b0); end
    st.push_back(0); mq.push_back(1'b1);
    st.push_back(1); mq.push_back(1'b1);
    if (op == R) begin st.push_back(6); st.push_back(7); mq.push_back(1'b1); mq.push_back(1'b1); end
    if (op == LW || op == SW) begin st.push_back(2); mq.push_back(1'b1); end
    for (int i = 0; i < mw && (op == LW || op == SW); i++) begin
      st.push_back(op == LW ? 3 : 5); mq.push_back(1'b0);
    end
    if (op == LW) begin st.push_back(3); st.push_back(4); mq.push_back(1'b1); mq.push_back(1'b1); end
    if (op == SW) begin st.push_back(5); mq.push_back(1'b1); end
    if (op == BEQ || op == BNE) begin st.push_back(8); mq.push_back(1'b1); end
    if (op == J) begin st.push_back(9); mq.push_back(1'b1); end
    if (op == ADDI || op == SLTI) begin st.push_back(10); st.push_back(11); mq.push_back(1'b1); mq.push_back(1'b1); end
    trace.delete();
    otrace.delete();
    for (int i = 0; i < st.size(); i++) begin
      bus0.opcode = op;
      bus0.mem_ready = mq[i];
      exp_state = 4'(st[i]);
      exp_o = exp_outs(st[i], op, mq[i]);
      exp_valid = 1'b1;
      @(posedge clk); #1;
    end
    exp_valid = 1'b0;
  endtask

  initial begin
    int lw_exp[5] = '{0, 1, 2, 3, 4};
    int cnt_a, cnt_b;
    logic [5:0] op1[9] = '{BNE, BNE, SLTI, SLTI, SW, SW, SW, SW, SW};
    int st1[9] = '{0, 1, 0, 1, 0, 1, 2, 5, 0};
    bus0.opcode = R; bus0.mem_ready = 1'b1;
    bus1.opcode = R; bus1.mem_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_state", {28'd0, bus0.state}, 32'd0);
    chk("reset_strobes", {25'd0, strobes0()}, 32'd0);
    @(negedge clk);
    chk("reset_strobes_held", {25'd0, strobes0()}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run(LW, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("lw_trace", {28'd0, trace[i]}, lw_exp[i]);
      chk("lw_reg_write", {31'd0, otrace[i].reg_write}, i == 4);
      chk("lw_mem_to_reg", {31'd0, otrace[i].mem_to_reg}, i == 4);
    end

    run(SW, 0, 3);
    cnt_a = 0; cnt_b = 0;
    foreach (otrace[i]) begin cnt_a += otrace[i].mem_write; cnt_b += otrace[i].reg_write; end
    chk("sw_mem_write_cycles", cnt_a, 4);
    chk("sw_reg_write_cycles", cnt_b, 0);
    chk("sw_length", otrace.size(), 7);

    run(BNE, 0, 0);
    chk("bne_state", {28'd0, trace[2]}, 8);
    chk("bne_branch_ne", {31'd0, otrace[2].branch_ne}, 1);
    chk("bne_alu_op", {29'd0, otrace[2].alu_op}, 5);
    chk("bne_pc_write_cond", {31'd0, otrace[2].pc_write_cond}, 1);
    run(BEQ, 0, 0);
    chk("beq_alu_op", {29'd0, otrace[2].alu_op}, 1);

    run(R, 5, 0);
    cnt_a = 0; cnt_b = 0;
    foreach (otrace[i]) begin cnt_a += otrace[i].ir_write; cnt_b += otrace[i].pc_write; end
    chk("stall_ir_write_pulses", cnt_a, 1);
    chk("stall_pc_write_pulses", cnt_b, 1);
    chk("stall_ir_write_at_rise", {31'd0, otrace[5].ir_write}, 1);

    run(ADDI, 0, 0);
    chk("addi_alu_op", {29'd0, otrace[2].alu_op}, 3);
    run(SLTI, 0, 0);
    chk("slti_alu_op", {29'd0, otrace[2].alu_op}, 4);
    run(J, 0, 0);
    chk("j_pc_source", {30'd0, otrace[2].pc_source}, 2);
    chk("j_pc_write", {31'd0, otrace[2].pc_write}, 1);

    run(LW, 2, 2);
    run(SW, 1, 0);
    run(BAD, 0, 0);
    chk("bad_illegal", {31'd0, otrace[1].illegal}, 1);
    chk("bad_length", trace.size(), 2);

    bus0.opcode = LW; bus0.mem_ready = 1'b1;
    @(posedge clk); #1 chk("rst_seq_decode", {28'd0, bus0.state}, 1);
    @(posedge clk); #1 chk("rst_seq_memadr", {28'd0, bus0.state}, 2);
    bus0.mem_ready = 1'b0;
    @(posedge clk); #1 chk("rst_seq_memrd", {28'd0, bus0.state}, 3);
    chk("rst_seq_mem_read", {31'd0, bus0.mem_read}, 1);
    #2 rst = 1'b1; bus0.mem_ready = 1'b1;
    #1 chk("async_rst_state", {28'd0, bus0.state}, 0);
    chk("async_rst_strobes", {25'd0, strobes0()}, 0);
    @(posedge clk); #1 chk("async_rst_state_held", {28'd0, bus0.state}, 0);
    chk("async_rst_strobes_held", {25'd0, strobes0()}, 0);
    rst = 1'b0;
    run(R, 0, 0);

    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus1.opcode = op1[c];
      bus1.mem_ready = 1'b0;
      @(negedge clk);
      chk("u1_state", {28'd0, bus1.state}, st1[c]);
      chk("u1_illegal", {31'd0, bus1.illegal}, st1[c] == 1 && op1[c] != SW);
      chk("u1_ir_write", {31'd0, bus1.ir_write}, st1[c] == 0);
      chk("u1_mem_write", {31'd0, bus1.mem_write}, st1[c] == 5);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
